// File: rtl/jk_excitation_gen.sv
// J/K excitation generator: turns a target word into a one-cycle J/K pulse for a JK flip-flop bank.
// Optional Q feedback verification with timeout/ERR is enabled by defining JKGEN_VERIFY_EN.
module jk_excitation_gen #(
  parameter int WIDTH    = 4,
  parameter int ENC_MODE = 0,
  parameter int TIMEOUT  = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] TGT,
  input  logic             TGT_VALID,
  output logic             TGT_READY,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             DONE,
  output logic             ERR,
  input  logic             CLR_ERR
);

  if (TIMEOUT < 1) begin : g_timeout_invalid
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ERROR} state_t;

  state_t           state;
  logic [WIDTH-1:0] j_calc;
  logic [WIDTH-1:0] k_calc;
  logic             accept;

  // Bits already at target get J=K=0 in both encodings.
  always_comb begin
    if (ENC_MODE == 1) begin
      j_calc = TGT ^ Q_FB;
      k_calc = TGT ^ Q_FB;
    end else begin
      j_calc = TGT & ~Q_FB;
      k_calc = ~TGT & Q_FB;
    end
  end

  assign TGT_READY = (state == IDLE);
  assign accept    = TGT_VALID && TGT_READY;

`ifdef JKGEN_VERIFY_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tgt_r;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      J     <= '0;
      K     <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      cnt   <= '0;
      tgt_r <= '0;
    end else begin
      DONE <= 1'b0;
      J    <= '0;
      K    <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_r <= TGT;
            if (TGT == Q_FB) begin
              DONE <= 1'b1;
            end else begin
              J     <= j_calc;
              K     <= k_calc;
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (Q_FB == tgt_r) begin
            DONE  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ERR   <= 1'b1;
            state <= ERROR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERROR: begin
          if (CLR_ERR) begin
            ERR   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = CLR_ERR;
  assign ERR            = 1'b0;

  // Without verification the block only drives: DRIVE returns straight to IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      J     <= '0;
      K     <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      J    <= '0;
      K    <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (TGT == Q_FB) begin
              DONE <= 1'b1;
            end else begin
              J     <= j_calc;
              K     <= k_calc;
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: doc/jk_excitation_gen.md
Name: jk_excitation_gen

Overview:
- Drives a bank of WIDTH positive-edge JK flip-flops on the same CLK toward a requested target value.
- Accepts one target word per valid/ready handshake and computes the J/K excitation from the target and the bank's current Q.
- Pulses J/K for exactly one cycle, then optionally checks that the bank's Q feedback reached the target.
- Sits between sequencing/control logic and any register built from JK flip-flop cells.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (bits of TGT, J, K, Q_FB).
- ENC_MODE, 0, excitation encoding. 0 = set/reset: J=d&~q, K=~d&q. 1 = toggle: J=K=d^q.
- TIMEOUT, 3, settle cycles allowed for Q_FB to match before ERR; must be >=1.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  asynchronous active-low reset.
- TGT  input  WIDTH  requested next value of the JK bank.
- TGT_VALID  input  1  TGT is valid.
- TGT_READY  output  1  block can accept a target.
- Q_FB  input  WIDTH  Q outputs of the driven JK bank.
- J  output  WIDTH  J inputs of the bank (registered).
- K  output  WIDTH  K inputs of the bank (registered).
- DONE  output  1  one-cycle pulse: target reached (or driven, without verify).
- ERR  output  1  sticky: bank failed to reach target within TIMEOUT.
- CLR_ERR  input  1  clears ERR and the ERROR state.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE, J=0, K=0, DONE=0, ERR=0, timeout counter=0, tgt_r=0. After release, TGT_READY=1.
- TGT_READY = (state==IDLE); combinational from the state register.
- IDLE: on an edge with TGT_VALID&TGT_READY, latch TGT into tgt_r.
  - If TGT==Q_FB: stay IDLE, DONE=1 next cycle, J/K remain 0.
  - Otherwise: register J/K from TGT and Q_FB (per ENC_MODE) and go to DRIVE.
- DRIVE (exactly 1 cycle): J/K hold the computed excitation; the bank samples it on the edge ending DRIVE. Next edge: J=K=0, counter=0, go to SETTLE.
- SETTLE: J=K=0.
  - If Q_FB==tgt_r: DONE=1 for one cycle, go to IDLE.
  - Else: counter+1. If counter reaches TIMEOUT-1 without a match, go to ERROR and set ERR=1.
  - Counter width is clog2(TIMEOUT+1).
- ERROR: TGT_READY=0, J=K=0, ERR=1. CLR_ERR high on an edge clears ERR and returns to IDLE. CLR_ERR in any other state has no effect.
- Latency with an ideal bank on the same CLK:
  - accept edge E0 -> DRIVE in cycle E0..E1 -> Q updates at E1 -> match in SETTLE -> DONE high and TGT_READY high after E2.
  - Throughput: one changing target per 3 cycles; one unchanged target per cycle.
- Bits where the target equals the current Q always get J=K=0 in both modes.
- TGT_VALID while TGT_READY=0: not accepted; the source must hold it.
- Q_FB changes outside SETTLE are ignored. Q_FB is sampled at accept for the excitation and in SETTLE for the check.
- DONE is never asserted in the same cycle as ERR rising.
- Reset mid-DRIVE or mid-SETTLE aborts immediately to reset values; no DONE is issued.

Optional Feature:
- Macro JKGEN_VERIFY_EN.
- Defined: SETTLE, timeout counter, ERROR, ERR and CLR_ERR behave as above.
- Undefined: SETTLE and ERROR do not exist. DRIVE goes directly to IDLE with DONE=1 in the following cycle. ERR is tied 0, CLR_ERR is ignored, TIMEOUT is unused. Throughput is one changing target per 2 cycles.

Test Plan:
- Set/reset encoding: ENC_MODE=0, WIDTH=4, bank Q=4'b0011, send TGT=4'b0101 -> DRIVE shows J=4'b0100, K=4'b0010; next cycle Q=0101; DONE pulses 2 cycles after DRIVE; ERR=0.
- Toggle encoding: ENC_MODE=1, Q=4'b1111, TGT=4'b0000 -> J=K=4'b1111 for one cycle; Q=0000; DONE=1.
- No-change target: Q=4'b1010, TGT=4'b1010 -> J=K=0 throughout, DONE the next cycle, TGT_READY stays 1; back-to-back accepts every cycle.
- Timeout (verify on): bank bit 0 stuck at 0, TIMEOUT=3, TGT=4'b0001 -> after DRIVE, 3 SETTLE cycles, then ERR=1 and TGT_READY=0; CLR_ERR pulse -> ERR=0, TGT_READY=1.
- Backpressure: hold TGT_VALID=1 with a new value during DRIVE/SETTLE -> not accepted until IDLE; accepted exactly once.
- Async reset mid-DRIVE: assert nRST low between edges -> J=K=0, DONE=0, ERR=0 immediately; TGT_READY=1 after release.
